ps2_scancode_receiver: RTL and testbench

// - Upstream stage of the servo arm controller. Receives PS/2 keyboard frames and decodes make/break/extended prefixes.
// - Its 'character' output drives the arm controller's 8-bit character input directly.
// - The arm controller maps the make codes 2B, 15, 33 and 22 (hex) to servo positions.
// - Runs entirely in the Pixelclock domain. PS/2 lines are asynchronous inputs.

---
 rtl/ps2_scancode_receiver.sv | 192 +++++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver with make/break/extended prefix decoding, Pixelclock domain.
// Optional build macro RELEASE_CLEAR_EN: a release of the key held in 'character' clears it to 00.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Pixelclock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] character,
  output logic       code_valid,
  output logic [7:0] code_out,
  output logic       code_break,
  output logic       code_ext,
  output logic       frame_err
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0] raw_lines;
  logic [1:0] filt_lines;

  assign raw_lines = {ps2_data, ps2_clk};

  // Bit 0 is the PS/2 clock, bit 1 the PS/2 data line; both get the same sync + debounce path.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic           meta_reg;
      logic           sync_reg;
      logic           filt_reg;
      logic [FCW-1:0] cnt_reg;

      always_ff @(posedge Pixelclock or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
          filt_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          meta_reg <= raw_lines[gi];
          sync_reg <= meta_reg;
          if (sync_reg != filt_reg) begin
            if (cnt_reg == FCW'(FILTER_LEN - 1)) begin
              filt_reg <= sync_reg;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign filt_lines[gi] = filt_reg;
    end
  endgenerate

  logic clk_prev_reg;
  logic fall;
  logic data_bit;

  assign fall     = clk_prev_reg & ~filt_lines[0];
  assign data_bit = filt_lines[1];

  always_ff @(posedge Pixelclock or negedge reset_n) begin
    if (!reset_n) clk_prev_reg <= 1'b1;
    else          clk_prev_reg <= filt_lines[0];
  end

  logic [1:0]     state_reg;
  logic [2:0]     bitcnt_reg;
  logic [7:0]     shift_reg;
  logic           parity_reg;
  logic [TCW-1:0] tcnt_reg;
  logic           break_pending_reg;
  logic           ext_pending_reg;
  logic [7:0]     character_reg;
  logic           code_valid_reg;
  logic [7:0]     code_out_reg;
  logic           code_break_reg;
  logic           code_ext_reg;
  logic           frame_err_reg;
`ifdef RELEASE_CLEAR_EN
  logic           char_ext_reg;
`endif

  logic frame_ok;
  assign frame_ok = data_bit & ((^shift_reg) ^ parity_reg);

  always_ff @(posedge Pixelclock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      bitcnt_reg        <= '0;
      shift_reg         <= '0;
      parity_reg        <= 1'b0;
      tcnt_reg          <= '0;
      break_pending_reg <= 1'b0;
      ext_pending_reg   <= 1'b0;
      character_reg     <= '0;
      code_valid_reg    <= 1'b0;
      code_out_reg      <= '0;
      code_break_reg    <= 1'b0;
      code_ext_reg      <= 1'b0;
      frame_err_reg     <= 1'b0;
`ifdef RELEASE_CLEAR_EN
      char_ext_reg      <= 1'b0;
`endif
    end else begin
      code_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      if (fall || state_reg == ST_IDLE) begin
        tcnt_reg <= '0;
      end else if (tcnt_reg == TCW'(TIMEOUT_CYCLES - 1)) begin
        // Keyboard went quiet mid-frame: drop the partial frame and any pending prefix.
        tcnt_reg          <= '0;
        state_reg         <= ST_IDLE;
        frame_err_reg     <= 1'b1;
        break_pending_reg <= 1'b0;
        ext_pending_reg   <= 1'b0;
      end else begin
        tcnt_reg <= tcnt_reg + 1'b1;
      end

      if (fall) begin
        case (state_reg)
          ST_IDLE: begin
            if (!data_bit) begin
              state_reg  <= ST_DATA;
              bitcnt_reg <= '0;
            end
          end
          ST_DATA: begin
            shift_reg <= {data_bit, shift_reg[7:1]};
            if (bitcnt_reg == 3'd7) state_reg <= ST_PARITY;
            else                    bitcnt_reg <= bitcnt_reg + 1'b1;
          end
          ST_PARITY: begin
            parity_reg <= data_bit;
            state_reg  <= ST_STOP;
          end
          default: begin
            state_reg <= ST_IDLE;
            if (!frame_ok) begin
              frame_err_reg     <= 1'b1;
              break_pending_reg <= 1'b0;
              ext_pending_reg   <= 1'b0;
            end else if (shift_reg == 8'hF0) begin
              break_pending_reg <= 1'b1;
            end else if (shift_reg == 8'hE0) begin
              ext_pending_reg <= 1'b1;
            end else begin
              code_valid_reg    <= 1'b1;
              code_out_reg      <= shift_reg;
              code_break_reg    <= break_pending_reg;
              code_ext_reg      <= ext_pending_reg;
              break_pending_reg <= 1'b0;
              ext_pending_reg   <= 1'b0;
              if (!break_pending_reg) begin
                character_reg <= shift_reg;
`ifdef RELEASE_CLEAR_EN
                char_ext_reg  <= ext_pending_reg;
`endif
              end
`ifdef RELEASE_CLEAR_EN
              else if (shift_reg == character_reg && ext_pending_reg == char_ext_reg) begin
                character_reg <= 8'h00;
              end
`endif
            end
          end
        endcase
      end
    end
  end

  assign character  = character_reg;
  assign code_valid = code_valid_reg;
  assign code_out   = code_out_reg;
  assign code_break = code_break_reg;
  assign code_ext   = code_ext_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver; expectations follow RELEASE_CLEAR_EN when it is defined.
module tb_ps2_scancode_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 20;

  logic       Pixelclock = 1'b0;
  logic       reset_n    = 1'b0;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic [7:0] character;
  logic       code_valid;
  logic [7:0] code_out;
  logic       code_break;
  logic       code_ext;
  logic       frame_err;

  ps2_scancode_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Pixelclock(Pixelclock),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .character (character),
    .code_valid(code_valid),
    .code_out  (code_out),
    .code_break(code_break),
    .code_ext  (code_ext),
    .frame_err (frame_err)
  );

  always #5 Pixelclock = ~Pixelclock;

  int         n_asserts = 0;
  int         n_fail    = 0;
  int         vcnt      = 0;
  int         ecnt      = 0;
  logic [7:0] cap_out   = 8'h00;
  logic       cap_break = 1'b0;
  logic       cap_ext   = 1'b0;
  int         v0;
  int         e0;

  always @(negedge Pixelclock) begin
    if (code_valid === 1'b1) begin
      vcnt      = vcnt + 1;
      cap_out   = code_out;
      cap_break = code_break;
      cap_ext   = code_ext;
    end
    if (frame_err === 1'b1) ecnt = ecnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(posedge Pixelclock);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge Pixelclock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_parity);
    send_bit(1'b1);
    repeat (HALF) @(posedge Pixelclock);
  endtask

  task automatic mark;
    v0 = vcnt;
    e0 = ecnt;
  endtask

  initial begin
    repeat (5) @(posedge Pixelclock);
    @(negedge Pixelclock);
    check("rst_character", 32'(character), 32'h00);
    check("rst_code_valid", 32'(code_valid), 32'h0);
    check("rst_code_out", 32'(code_out), 32'h00);
    check("rst_flags", 32'({code_break, code_ext, frame_err}), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge Pixelclock);

    // Plain make code 2B
    mark();
    send_frame(8'h2B, 1'b0);
    check("t1_valid_pulses", 32'(vcnt - v0), 32'd1);
    check("t1_code_out", 32'(cap_out), 32'h2B);
    check("t1_break_ext", 32'({cap_break, cap_ext}), 32'h0);
    check("t1_character", 32'(character), 32'h2B);
    check("t1_no_err", 32'(ecnt - e0), 32'd0);

    // Release of 2B
    mark();
    send_frame(8'hF0, 1'b0);
    check("t2_prefix_silent", 32'(vcnt - v0), 32'd0);
    send_frame(8'h2B, 1'b0);
    check("t2_valid_pulses", 32'(vcnt - v0), 32'd1);
    check("t2_code_out", 32'(cap_out), 32'h2B);
    check("t2_break_ext", 32'({cap_break, cap_ext}), 32'h2);
`ifdef RELEASE_CLEAR_EN
    check("t2_character", 32'(character), 32'h00);
`else
    check("t2_character", 32'(character), 32'h2B);
`endif
    check("t2_valid_low", 32'(code_valid), 32'h0);

    // Extended make E0 75
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("t3_valid_pulses", 32'(vcnt - v0), 32'd1);
    check("t3_break_ext", 32'({cap_break, cap_ext}), 32'h1);
    check("t3_character", 32'(character), 32'h75);

    // Parity error on 22, then a clean 22
    mark();
    send_frame(8'h22, 1'b1);
    check("t4_err_pulses", 32'(ecnt - e0), 32'd1);
    check("t4_no_valid", 32'(vcnt - v0), 32'd0);
    check("t4_character", 32'(character), 32'h75);
    check("t4_err_low", 32'(frame_err), 32'h0);
    send_frame(8'h22, 1'b0);
    check("t4_clean_character", 32'(character), 32'h22);

    // Partial frame, then timeout
    mark();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TIMEOUT + 50) @(posedge Pixelclock);
    check("t5_timeout_err", 32'(ecnt - e0), 32'd1);
    check("t5_no_valid", 32'(vcnt - v0), 32'd0);
    mark();
    send_frame(8'h15, 1'b0);
    check("t5_character", 32'(character), 32'h15);
    check("t5_valid_pulses", 32'(vcnt - v0), 32'd1);
    check("t5_no_err", 32'(ecnt - e0), 32'd0);

    // E0 F0 75: extended release of a key other than the held one
    mark();
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check("t5b_break_ext", 32'({cap_break, cap_ext}), 32'h3);
    check("t5b_code_out", 32'(cap_out), 32'h75);
    check("t5b_character", 32'(character), 32'h15);

    // Short low glitch on ps2_clk with data low must not start a frame
    mark();
    ps2_data = 1'b0;
    repeat (HALF) @(posedge Pixelclock);
    ps2_clk = 1'b0;
    repeat (3) @(posedge Pixelclock);
    ps2_clk = 1'b1;
    repeat (HALF) @(posedge Pixelclock);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge Pixelclock);
    send_frame(8'h33, 1'b0);
    check("t6_glitch_character", 32'(character), 32'h33);
    check("t6_glitch_no_err", 32'(ecnt - e0), 32'd0);

    // Reset in the middle of a frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset_n  = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(posedge Pixelclock);
    @(negedge Pixelclock);
    check("t6_rst_character", 32'(character), 32'h00);
    check("t6_rst_code_out", 32'(code_out), 32'h00);
    check("t6_rst_flags", 32'({code_valid, code_break, code_ext, frame_err}), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(posedge Pixelclock);
    mark();
    send_frame(8'h33, 1'b0);
    check("t6_after_rst_character", 32'(character), 32'h33);
    check("t6_after_rst_valid", 32'(vcnt - v0), 32'd1);
    check("t6_after_rst_flags", 32'({cap_break, cap_ext}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
